// File: rtl/led_blink_if.sv
// Request channel for the LED blink scheduler.
// Two requesters, each presenting a burst blink count over valid/ready.
interface led_blink_if #(
    parameter int unsigned CNT_W = 4
);
    logic             req0_valid;
    logic [CNT_W-1:0] req0_count;
    logic             req0_ready;
    logic             req1_valid;
    logic [CNT_W-1:0] req1_count;
    logic             req1_ready;

    modport master (
        output req0_valid, req0_count, req1_valid, req1_count,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_count, req1_valid, req1_count,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/led_blink_scheduler.sv
// Shares one status LED between two requesters: round-robin grant of blink
// bursts, each played as tick-timed ON/OFF blinks followed by a dark GAP.
module led_blink_scheduler #(
    parameter int unsigned TICK_DIV  = 5_000_000,
    parameter int unsigned ON_TICKS  = 4,
    parameter int unsigned OFF_TICKS = 4,
    parameter int unsigned GAP_TICKS = 10,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    led_blink_if.slave  req,
    output logic        led,
    output logic        busy,
    output logic        grant_id,
    output logic        done
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned PH_MAX = (ON_TICKS > OFF_TICKS)
                                     ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                                     : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ON        = 3'd1;
    localparam logic [2:0] OFF       = 3'd2;
    localparam logic [2:0] GAP       = 3'd3;
    localparam logic [2:0] DONE_ZERO = 3'd4;

    logic [2:0]        state, state_d;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic [CNT_W-1:0]  remaining, remaining_d;
    logic              last_grant, last_grant_d;
    logic              grant_d, led_d, done_d, busy_d;
    logic              tick, ready0, ready1, acc0, acc1;
    logic [CNT_W-1:0]  acc_count;

    // Arbitration is only open in IDLE; a tie goes to whoever was not served last.
    assign ready0 = (state == IDLE) && !rst && req.req0_valid
                    && (!req.req1_valid || last_grant);
    assign ready1 = (state == IDLE) && !rst && req.req1_valid
                    && (!req.req0_valid || !last_grant);
    assign req.req0_ready = ready0;
    assign req.req1_ready = ready1;
    assign acc0      = ready0 && req.req0_valid;
    assign acc1      = ready1 && req.req1_valid;
    assign acc_count = acc1 ? req.req1_count : req.req0_count;
    assign tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            phase      <= '0;
            remaining  <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            led        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            tick_cnt   <= tick_cnt_d;
            phase      <= phase_d;
            remaining  <= remaining_d;
            last_grant <= last_grant_d;
            grant_id   <= grant_d;
            led        <= led_d;
            done       <= done_d;
            busy       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state;
        tick_cnt_d   = tick ? '0 : tick_cnt + TICK_W'(1);
        phase_d      = phase;
        remaining_d  = remaining;
        last_grant_d = last_grant;
        grant_d      = grant_id;
        led_d        = 1'b0;
        done_d       = 1'b0;

        case (state)
            IDLE: begin
                if (acc0 || acc1) begin
                    // Restart the tick so every phase is a whole number of ticks.
                    tick_cnt_d   = '0;
                    phase_d      = '0;
                    remaining_d  = acc_count;
                    grant_d      = acc1;
                    last_grant_d = acc1;
                    if (acc_count != '0) begin
                        state_d = ON;
                        led_d   = 1'b1;
                    end else begin
                        state_d = DONE_ZERO;
                    end
                end
            end
            ON: begin
                led_d = 1'b1;
                if (tick) begin
                    if (phase == PH_W'(ON_TICKS - 1)) begin
                        state_d = OFF;
                        led_d   = 1'b0;
                        phase_d = '0;
                    end else begin
                        phase_d = phase + PH_W'(1);
                    end
                end
            end
            OFF: begin
                if (tick) begin
                    if (phase == PH_W'(OFF_TICKS - 1)) begin
                        phase_d     = '0;
                        remaining_d = remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state_d = GAP;
                        end else begin
                            state_d = ON;
                            led_d   = 1'b1;
                        end
                    end else begin
                        phase_d = phase + PH_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (phase == PH_W'(GAP_TICKS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        phase_d = '0;
                    end else begin
                        phase_d = phase + PH_W'(1);
                    end
                end
            end
            DONE_ZERO: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Randomized and directed bench for led_blink_scheduler against a timeline
// model derived from burst start time and blink count.
module tb_led_blink_scheduler;

    localparam int TD   = 4;
    localparam int ONT  = 2;
    localparam int OFFT = 1;
    localparam int GAPT = 3;
    localparam int CW   = 4;
    localparam int P    = (ONT + OFFT) * TD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic led, busy, grant_id, done;

    led_blink_if #(.CNT_W(CW)) bus ();

    led_blink_scheduler #(
        .TICK_DIV  (TD),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .GAP_TICKS (GAPT),
        .CNT_W     (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (bus),
        .led      (led),
        .busy     (busy),
        .grant_id (grant_id),
        .done     (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus applied at the start of each step
    logic          s_rst = 1'b1;
    logic          s_v0  = 1'b0;
    logic          s_v1  = 1'b0;
    logic [CW-1:0] s_c0  = '0;
    logic [CW-1:0] s_c1  = '0;

    // Reference model: a burst is fully described by its accept time and count
    int now        = 0;
    bit rst_prev   = 1'b1;
    bit m_active   = 1'b0;
    bit m_started  = 1'b0;
    bit m_last     = 1'b1;
    bit m_grant    = 1'b0;
    int m_acc      = 0;
    int m_len      = 0;
    int m_cnt      = 0;

    // Observations of the DUT for directed checks
    bit   hs0, hs1;
    int   acc_q[$];
    int   last_acc      = 0;
    int   last_lat      = 0;
    int   rises         = 0;
    int   rises_at_done = 0;
    int   busy_cycles   = 0;
    int   busy_at_done  = 0;
    logic led_q         = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int burst_len(input int cnt);
        return (cnt == 0) ? 2 : cnt * P + GAPT * TD + 1;
    endfunction

    task automatic step();
        int k;
        bit e_led, e_done, e_busy, e_r0, e_r1;
        @(negedge clk);
        rst            = s_rst;
        bus.req0_valid = s_v0;
        bus.req0_count = s_c0;
        bus.req1_valid = s_v1;
        bus.req1_count = s_c1;
        #1;
        now++;
        if (rst_prev) begin
            m_active  = 1'b0;
            m_started = 1'b0;
            m_last    = 1'b1;
            m_grant   = 1'b0;
        end
        if (m_active && (now - m_acc) >= m_len) m_active = 1'b0;
        k      = now - m_acc;
        e_led  = m_active && (k >= 1) && ((k - 1) < m_cnt * P) && (((k - 1) % P) < ONT * TD);
        e_done = m_started && (k == m_len);
        e_busy = m_active;
        e_r0   = !s_rst && !m_active && s_v0 && (!s_v1 || m_last);
        e_r1   = !s_rst && !m_active && s_v1 && (!s_v0 || !m_last);

        chk("led", 32'(led), 32'(e_led));
        chk("done", 32'(done), 32'(e_done));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        chk("req0_ready", 32'(bus.req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(e_r1));

        if (e_r0 || e_r1) begin
            m_active  = 1'b1;
            m_started = 1'b1;
            m_acc     = now;
            m_cnt     = e_r1 ? int'(s_c1) : int'(s_c0);
            m_len     = burst_len(m_cnt);
            m_last    = e_r1;
            m_grant   = e_r1;
        end
        rst_prev = s_rst;

        if (led === 1'b1 && led_q !== 1'b1) rises++;
        led_q = led;
        if (busy === 1'b1) busy_cycles++;
        if (done === 1'b1) begin
            last_lat      = now - last_acc;
            rises_at_done = rises;
            busy_at_done  = busy_cycles;
        end
        hs0 = (bus.req0_ready === 1'b1) && s_v0;
        hs1 = (bus.req1_ready === 1'b1) && s_v1;
        if (hs0 || hs1) begin
            acc_q.push_back(hs1 ? 1 : 0);
            last_acc    = now;
            rises       = 0;
            busy_cycles = 0;
        end
    endtask

    task automatic run_until_idle();
        int n = 0;
        step();
        while (m_active && n < 2000) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(m_active), 32'd0);
    endtask

    task automatic wait_hs(input bit which);
        int n = 0;
        step();
        while (!(which ? hs1 : hs0) && n < 2000) begin
            step();
            n++;
        end
        chk("accept_timeout", 32'(which ? hs1 : hs0), 32'd1);
    endtask

    task automatic reset_dut();
        s_rst = 1'b1;
        step();
        step();
        s_rst = 1'b0;
    endtask

    function automatic logic [CW-1:0] rand_count();
        int r = int'($urandom % 10);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return CW'(1 + $urandom % 4);
    endfunction

    initial begin
        // Reset held with req0 pending, then a single count=3 burst
        s_v0 = 1'b1;
        s_c0 = 4'd3;
        repeat (3) step();
        s_rst = 1'b0;
        step();
        chk("first_ready0", 32'(hs0), 32'd1);
        s_v0 = 1'b0;
        run_until_idle();
        chk("lat_count3", 32'(last_lat), 32'd49);
        chk("blinks_count3", 32'(rises_at_done), 32'd3);
        chk("grant_count3", 32'(grant_id), 32'd0);

        // Round-robin with both requesters always valid
        reset_dut();
        acc_q.delete();
        s_v0 = 1'b1; s_c0 = 4'd1;
        s_v1 = 1'b1; s_c1 = 4'd2;
        for (int n = 0; n < 1000 && acc_q.size() < 4; n++) step();
        chk("rr_grants", 32'(acc_q.size()), 32'd4);
        for (int i = 0; i < acc_q.size() && i < 4; i++) chk("rr_order", 32'(acc_q[i]), 32'(i % 2));
        s_v0 = 1'b0;
        s_v1 = 1'b0;
        run_until_idle();

        // Zero-count burst
        s_v1 = 1'b1;
        s_c1 = 4'd0;
        wait_hs(1'b1);
        s_v1 = 1'b0;
        run_until_idle();
        chk("zero_lat", 32'(last_lat), 32'd2);
        chk("zero_busy", 32'(busy_at_done), 32'd1);
        chk("zero_blinks", 32'(rises_at_done), 32'd0);

        // Reset in the second ON phase of a count=5 burst
        s_v0 = 1'b1;
        s_c0 = 4'd5;
        wait_hs(1'b0);
        s_v0 = 1'b0;
        repeat (15) step();
        chk("pre_rst_led", 32'(led), 32'd1);
        s_rst = 1'b1;
        s_v0  = 1'b1;
        s_v1  = 1'b1;
        s_c1  = 4'd1;
        step();
        s_rst = 1'b0;
        acc_q.delete();
        step();
        chk("mid_rst_led", 32'(led), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_first", 32'(acc_q.size() > 0 ? acc_q[0] : 9), 32'd0);
        s_v0 = 1'b0;
        s_v1 = 1'b0;
        run_until_idle();

        // Request held off while busy, count changes before accept
        s_v0 = 1'b1;
        s_c0 = 4'd2;
        wait_hs(1'b0);
        s_v0 = 1'b0;
        s_v1 = 1'b1;
        s_c1 = 4'd2;
        repeat (5) begin
            step();
            chk("holdoff_ready1", 32'(bus.req1_ready), 32'd0);
        end
        s_c1 = 4'd7;
        wait_hs(1'b1);
        s_v1 = 1'b0;
        s_c1 = 4'd3;
        run_until_idle();
        chk("holdoff_blinks", 32'(rises_at_done), 32'd7);
        chk("holdoff_lat", 32'(last_lat), 32'(burst_len(7)));

        // Long count must not wrap
        s_v0 = 1'b1;
        s_c0 = 4'd15;
        wait_hs(1'b0);
        s_v0 = 1'b0;
        run_until_idle();
        chk("max_blinks", 32'(rises_at_done), 32'd15);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            s_rst = ($urandom % 1500 == 0);
            if (!s_v0 && ($urandom % 8 == 0)) begin s_v0 = 1'b1; s_c0 = rand_count(); end
            if (!s_v1 && ($urandom % 8 == 0)) begin s_v1 = 1'b1; s_c1 = rand_count(); end
            if (s_v0 && m_active && ($urandom % 40 == 0)) s_v0 = 1'b0;
            if (s_v1 && m_active && ($urandom % 40 == 0)) s_c1 = rand_count();
            step();
            if (hs0) begin s_v0 = ($urandom % 4 == 0); s_c0 = rand_count(); end
            if (hs1) begin s_v1 = ($urandom % 4 == 0); s_c1 = rand_count(); end
        end
        s_rst = 1'b0;
        s_v0  = 1'b0;
        s_v1  = 1'b0;
        run_until_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
